// File: rtl/multi_clock_divider_pkg.sv
// multi_clock_divider_pkg: shared output modes, reset count and channel-index sizing.
package multi_clock_divider_pkg;
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE = 1'b1;
  localparam int DEFAULT_COUNT_C = 2;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/divider_channel.sv
// divider_channel: one divider channel with shadowed count/mode applied at period boundaries.
module divider_channel
  import multi_clock_divider_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DEFAULT_COUNT = DEFAULT_COUNT_C
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_count,
  input  logic             load_mode,
  output logic             clock_out,
  output logic             tick,
  output logic             pending
);
  logic [CNT_W-1:0] cnt_q, cnt_d, active_count_q, active_count_d, shadow_count_q, shadow_count_d;
  logic active_mode_q, active_mode_d, shadow_mode_q, shadow_mode_d;
  logic pending_q, pending_d, clock_out_q, clock_out_d, tick_q, tick_d;
  logic run, wrap, pulse, boundary, apply;
  always_comb begin
    run = enable && (active_count_q != '0);
    wrap = cnt_q == active_count_q - CNT_W'(1);
    pulse = active_mode_q == MODE_PULSE;
    // toggle mode only lets a reload in on the falling wrap, so a high phase is never cut short
    boundary = run && wrap && (pulse || clock_out_q);
    apply = pending_q && (!run || boundary);
    cnt_d = (!run || wrap) ? '0 : cnt_q + CNT_W'(1);
    clock_out_d = !run ? 1'b0 : !wrap ? (!pulse && clock_out_q) : (pulse || !clock_out_q);
    tick_d = run && clock_out_d && (pulse || !clock_out_q);
    active_count_d = apply ? shadow_count_q : active_count_q;
    active_mode_d = apply ? shadow_mode_q : active_mode_q;
    shadow_count_d = load ? load_count : shadow_count_q;
    shadow_mode_d = load ? load_mode : shadow_mode_q;
    pending_d = load || (pending_q && !apply);
  end
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      active_count_q <= CNT_W'(DEFAULT_COUNT);
      shadow_count_q <= CNT_W'(DEFAULT_COUNT);
      active_mode_q <= MODE_TOGGLE;
      shadow_mode_q <= MODE_TOGGLE;
      pending_q <= 1'b0;
      clock_out_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      active_count_q <= active_count_d;
      shadow_count_q <= shadow_count_d;
      active_mode_q <= active_mode_d;
      shadow_mode_q <= shadow_mode_d;
      pending_q <= pending_d;
      clock_out_q <= clock_out_d;
      tick_q <= tick_d;
    end
  end
  assign clock_out = clock_out_q;
  assign tick = tick_q;
  assign pending = pending_q;
endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH programmable dividers sharing one clock and one load port.
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter int DEFAULT_COUNT = DEFAULT_COUNT_C,
  localparam int SEL_W = ch_idx_w(NUM_CH)
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              load,
  input  logic [SEL_W-1:0]  load_sel,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              load_mode,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);
  // out-of-range selects match no channel, so such loads vanish
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    divider_channel #(.CNT_W(CNT_W), .DEFAULT_COUNT(DEFAULT_COUNT)) u_ch (
      .clock_in(clock_in),
      .reset(reset),
      .enable(ch_enable[i]),
      .load(load && (load_sel == SEL_W'(i))),
      .load_count(load_count),
      .load_mode(load_mode),
      .clock_out(clock_out[i]),
      .tick(tick[i]),
      .pending(pending[i])
    );
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: directed scenarios with hand-computed waveforms on a 3-channel divider.
module tb_multi_clock_divider;
  logic clock_in, reset, load, load_mode;
  logic [2:0] ch_enable, clock_out, tick, pending;
  logic [1:0] load_sel;
  logic [31:0] load_count;
  int checks = 0;
  int errors = 0;

  multi_clock_divider #(.NUM_CH(3), .CNT_W(32), .DEFAULT_COUNT(2)) dut (
    .clock_in(clock_in), .reset(reset), .ch_enable(ch_enable), .load(load),
    .load_sel(load_sel), .load_count(load_count), .load_mode(load_mode),
    .clock_out(clock_out), .tick(tick), .pending(pending)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ch_enable = '0; load = 1'b0; load_sel = '0; load_count = '0; load_mode = 1'b0;
    step(); step();
    checks++; if (clock_out !== 3'b000) begin errors++; $display("FAIL reset_clock_out got=%b exp=000", clock_out); end
    checks++; if (tick !== 3'b000) begin errors++; $display("FAIL reset_tick got=%b exp=000", tick); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got=%b exp=000", pending); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_default_toggle();
    logic [0:7] e_co, e_tk;
    e_co = 8'b01100110;
    e_tk = 8'b01000100;
    ch_enable[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (clock_out[0] !== e_co[k]) begin errors++; $display("FAIL default_co k=%0d got=%b exp=%b", k, clock_out[0], e_co[k]); end
      checks++; if (tick[0] !== e_tk[k]) begin errors++; $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick[0], e_tk[k]); end
    end
  endtask

  task automatic test_pulse_load_disabled();
    logic [0:8] e;
    e = 9'b001001001;
    load = 1'b1; load_sel = 2'd1; load_count = 32'd3; load_mode = 1'b1;
    step();
    load = 1'b0;
    checks++; if (pending[1] !== 1'b1) begin errors++; $display("FAIL pulse_pending_set got=%b exp=1", pending[1]); end
    step();
    checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL pulse_pending_clear got=%b exp=0", pending[1]); end
    ch_enable[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++; if (clock_out[1] !== e[k]) begin errors++; $display("FAIL pulse_co k=%0d got=%b exp=%b", k, clock_out[1], e[k]); end
      checks++; if (tick[1] !== e[k]) begin errors++; $display("FAIL pulse_tick k=%0d got=%b exp=%b", k, tick[1], e[k]); end
    end
  endtask

  task automatic test_reload_high();
    logic [0:7] e;
    e = 8'b00011110;
    ch_enable[0] = 1'b0;
    step();
    ch_enable[0] = 1'b1;
    step(); step();
    checks++; if (clock_out[0] !== 1'b1) begin errors++; $display("FAIL reload_rise got=%b exp=1", clock_out[0]); end
    load = 1'b1; load_sel = 2'd0; load_count = 32'd4; load_mode = 1'b0;
    step();
    load = 1'b0;
    checks++; if (clock_out[0] !== 1'b1) begin errors++; $display("FAIL reload_high_kept got=%b exp=1", clock_out[0]); end
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL reload_pending got=%b exp=1", pending[0]); end
    step();
    checks++; if (clock_out[0] !== 1'b0) begin errors++; $display("FAIL reload_fall got=%b exp=0", clock_out[0]); end
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL reload_applied got=%b exp=0", pending[0]); end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (clock_out[0] !== e[k]) begin errors++; $display("FAIL reload_co k=%0d got=%b exp=%b", k, clock_out[0], e[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:26] e;
    e = 27'b000_1111_0_00000_111111_0_000000_1;
    for (int k = 0; k < 27; k++) begin
      load = (k == 4) || (k == 5) || (k == 7);
      load_sel = 2'd0; load_mode = 1'b0;
      load_count = (k == 4) ? 32'd5 : (k == 5) ? 32'd6 : 32'd7;
      step();
      checks++; if (clock_out[0] !== e[k]) begin errors++; $display("FAIL b2b_co k=%0d got=%b exp=%b", k, clock_out[0], e[k]); end
      if (k == 5 || k == 7 || k == 18) begin
        checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL b2b_pending k=%0d got=%b exp=1", k, pending[0]); end
      end
      if (k == 19) begin
        checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL b2b_applied got=%b exp=0", pending[0]); end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_invalid_and_zero();
    load = 1'b1; load_sel = 2'd3; load_count = 32'd9; load_mode = 1'b1;
    step();
    load = 1'b0;
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL bad_sel_pending got=%b exp=000", pending); end
    checks++; if (clock_out[2] !== 1'b0) begin errors++; $display("FAIL bad_sel_ch2 got=%b exp=0", clock_out[2]); end
    load = 1'b1; load_sel = 2'd2; load_count = 32'd0; load_mode = 1'b0;
    step();
    load = 1'b0;
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL zero_pending_set got=%b exp=1", pending[2]); end
    step();
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL zero_pending_clear got=%b exp=0", pending[2]); end
    ch_enable[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (clock_out[2] !== 1'b0) begin errors++; $display("FAIL zero_co k=%0d got=%b exp=0", k, clock_out[2]); end
      checks++; if (tick[2] !== 1'b0) begin errors++; $display("FAIL zero_tick k=%0d got=%b exp=0", k, tick[2]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [0:3] e;
    e = 4'b0110;
    ch_enable[0] = 1'b0;
    step();
    ch_enable[0] = 1'b1;
    for (int k = 0; k < 7; k++) step();
    checks++; if (clock_out[0] !== 1'b1) begin errors++; $display("FAIL mid_rise got=%b exp=1", clock_out[0]); end
    load = 1'b1; load_sel = 2'd0; load_count = 32'd10; load_mode = 1'b0;
    step();
    load = 1'b0;
    checks++; if (pending[0] !== 1'b1 || clock_out[0] !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b/%b exp=1/1", pending[0], clock_out[0]); end
    reset = 1'b0;
    #1;
    checks++; if (clock_out !== 3'b000) begin errors++; $display("FAIL mid_async_co got=%b exp=000", clock_out); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL mid_async_pending got=%b exp=000", pending); end
    checks++; if (tick !== 3'b000) begin errors++; $display("FAIL mid_async_tick got=%b exp=000", tick); end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (clock_out[0] !== e[k]) begin errors++; $display("FAIL mid_resume k=%0d got=%b exp=%b", k, clock_out[0], e[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_default_toggle();
    test_pulse_load_disabled();
    test_reload_high();
    test_back_to_back();
    test_invalid_and_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
